// File: rtl/bu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bu_pkg
// Description : Shared widths, reset PC, fetch FSM states and queue entry type
//               for the BU2020 instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bu_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps from the top of memory back to zero.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bu_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : bu_fetch_unit_if
// Description : Memory read bus, instruction handshake and redirect signals
//               between the fetch unit (master) and core/memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface bu_fetch_unit_if;
  import bu_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_addr, mem_rd, instr, instr_pc, instr_valid,
    input  mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd, instr, instr_pc, instr_valid,
    output mem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/bu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : bu_fetch_queue
// Description : Synchronous prefetch FIFO of fetch_entry_t. Flush beats push.
//               DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module bu_fetch_queue
  import bu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer/occupancy bookkeeping; flush empties the queue and wins over push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : bu_fetch_unit
// Description : BU2020 instruction fetch stage. Owns the PC, issues one read
//               per cycle, buffers returned words in a prefetch queue and
//               hands them to the core over valid/ready. Redirects flush.
//               Optional macro FETCH_STALL_CNT_EN adds the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module bu_fetch_unit #(
  parameter logic [bu_pkg::ADDR_W-1:0] RESET_PC = bu_pkg::RESET_PC,
  parameter int                        QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  bu_fetch_unit_if.master  bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  import bu_pkg::*;

  localparam int c_cnt_w = $clog2(QDEPTH) + 1;
  localparam int c_occ_w = c_cnt_w + 1;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               w_issue;
  logic               w_pop;
  logic               w_push;
  logic               w_room;
  logic [c_occ_w-1:0] w_occ;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic [c_cnt_w-1:0] w_count;
  logic               w_full;
  logic               w_empty;

  assign w_pop        = ~w_empty & bus.instr_ready;
  // A redirect cancels the word returning this cycle: it belongs to the old path.
  assign w_push       = r_inflight & ~bus.redirect;
  assign w_push_entry = '{pc: r_inflight_pc, instr: bus.mem_rdata};
  // Occupancy the queue would have if nothing new were issued this cycle.
  assign w_occ        = c_occ_w'(w_count) + c_occ_w'(r_inflight) - c_occ_w'(w_pop);
  assign w_room       = (w_occ < c_occ_w'(QDEPTH));

  assign bus.mem_rd      = w_issue;
  assign bus.mem_addr    = r_fetch_pc;
  assign bus.instr       = w_head.instr;
  assign bus.instr_pc    = w_head.pc;
  assign bus.instr_valid = ~w_empty;

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state follows en; reads are issued only in RUN when the queue has room.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (!en) w_state_nxt = IDLE;
        w_issue = ~bus.redirect & w_room;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // PC and single outstanding read tracking; redirect overrides sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
      if (bus.redirect)  r_fetch_pc <= bus.redirect_pc;
      else if (w_issue)  r_fetch_pc <= next_pc(r_fetch_pc);
    end
  end

  bu_fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push & (~w_full | w_pop)),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .flush      (bus.redirect),
    .head       (w_head),
    .count      (w_count),
    .full       (w_full),
    .empty      (w_empty)
  );

  // The issue rule must never let a returning word meet a full, non-draining queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where the core holds off a valid instruction; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !bus.instr_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
